// File: rtl/uart_text_writer_if.sv
// Serial-in / text-RAM-write bundle for uart_text_writer; master = the writer, slave = RAM/observer side.
// No latency or backpressure of its own: the RAM write port always accepts.
interface uart_text_writer_if #(
    parameter int ADDR_W = 12
);
    logic              rx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic              clear_busy;
    logic              frame_err;
    logic              overrun;

    modport master (
        input  rx,
        output wr_en, wr_addr, wr_data, cursor_col, cursor_row,
        output clear_busy, frame_err, overrun
    );

    modport slave (
        output rx,
        input  wr_en, wr_addr, wr_data, cursor_col, cursor_row,
        input  clear_busy, frame_err, overrun
    );
endinterface

// File: rtl/uart_text_writer.sv
// UART byte receiver feeding a text-RAM writer with cursor control and a clear sweep; write lands 1 cycle after a byte is consumed.
// No backpressure to the line: one held byte, later bytes dropped with an overrun pulse while it is still full.
module uart_text_writer #(
    parameter int CLKS_PER_BIT = 100,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int ADDR_W       = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_text_writer_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_M1    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [7:0]        SPACE     = 8'h20;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HI
    } rx_state_t;

    typedef enum logic [1:0] {
        CLR_ARM,
        CLR_RUN,
        CLR_IDLE
    } clr_state_t;

    // ---------------- receiver ----------------
    logic             rx_meta_q, rx_sync_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_vld;
    logic             frame_err_q, frame_err_d;

    // ---------------- holding register ----------------
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] hold_dat_q, hold_dat_d;
    logic       overrun_q, overrun_d;
    logic       consume;

    // ---------------- writer / cursor ----------------
    clr_state_t        clr_state_q, clr_state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              row_adv;
    logic              start_sweep;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        byte_vld    = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Mid-start-bit recheck rejects short glitches silently.
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_vld   = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT_HI;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_WAIT_HI: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign consume = hold_vld_q && (clr_state_q == CLR_IDLE);

    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_dat_d = hold_dat_q;
        overrun_d  = 1'b0;
        if (consume) begin
            hold_vld_d = 1'b0;
        end
        // A byte consumed this cycle frees the slot for one arriving this cycle.
        if (byte_vld) begin
            if (!hold_vld_q || consume) begin
                hold_vld_d = 1'b1;
                hold_dat_d = rx_shift_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        clr_state_d = clr_state_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        col_d       = col_q;
        row_d       = row_q;
        row_base_d  = row_base_q;
        row_adv     = 1'b0;
        start_sweep = 1'b0;

        case (clr_state_q)
            CLR_ARM: start_sweep = 1'b1;
            CLR_RUN: begin
                // wr_addr_q doubles as the sweep pointer.
                if (wr_addr_q == LAST_CELL) begin
                    clr_state_d = CLR_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                    wr_data_d = SPACE;
                end
            end
            CLR_IDLE: begin
                if (consume) begin
                    if (hold_dat_q >= 8'h20 && hold_dat_q <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = row_base_q + ADDR_W'(col_q);
                        wr_data_d = hold_dat_q;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            row_adv = 1'b1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (hold_dat_q)
                            8'h0D: col_d = '0;
                            8'h0A: begin
                                col_d   = '0;
                                row_adv = 1'b1;
                            end
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d     = col_q - 7'd1;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = row_base_q + ADDR_W'(col_q) - ADDR_ONE;
                                    wr_data_d = SPACE;
                                end
                            end
                            8'h0C:   start_sweep = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            default: clr_state_d = CLR_IDLE;
        endcase

        if (row_adv) begin
            if (row_q == LAST_ROW) begin
                row_d      = '0;
                row_base_d = '0;
            end else begin
                row_d      = row_q + 5'd1;
                row_base_d = row_base_q + COLS_A;
            end
        end

        if (start_sweep) begin
            clr_state_d = CLR_RUN;
            wr_en_d     = 1'b1;
            wr_addr_d   = '0;
            wr_data_d   = SPACE;
            col_d       = '0;
            row_d       = '0;
            row_base_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            frame_err_q <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_dat_q  <= '0;
            overrun_q   <= 1'b0;
            clr_state_q <= CLR_ARM;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
        end else begin
            rx_meta_q   <= bus.rx;
            rx_sync_q   <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            frame_err_q <= frame_err_d;
            hold_vld_q  <= hold_vld_d;
            hold_dat_q  <= hold_dat_d;
            overrun_q   <= overrun_d;
            clr_state_q <= clr_state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.cursor_col = col_q;
    assign bus.cursor_row = row_q;
    assign bus.clear_busy = (clr_state_q == CLR_RUN);
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_text_writer.sv
// Bench for uart_text_writer: serial stimulus, write-stream capture and a cell-position reference model.
module tb_uart_text_writer;
    localparam int CPB   = 16;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int CELLS = COLS * ROWS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_text_writer_if #(.ADDR_W(AW)) bus ();

    uart_text_writer #(
        .CLKS_PER_BIT(CPB),
        .COLS        (COLS),
        .ROWS        (ROWS),
        .ADDR_W      (AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    int got_addr[$];
    int got_dat[$];
    int exp_addr[$];
    int exp_dat[$];
    int gi = 0;
    int ei = 0;

    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int busy_cyc = 0;

    // Model cursor as a linear cell index row*COLS+col.
    int mpos = 0;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            got_addr.push_back(int'(bus.wr_addr));
            got_dat.push_back(int'(bus.wr_data));
        end
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.overrun === 1'b1) ov_cnt++;
        if (bus.clear_busy === 1'b1) busy_cyc++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int a, input int d);
        exp_addr.push_back(a);
        exp_dat.push_back(d);
    endtask

    task automatic model_byte(input int b);
        if (b >= 32 && b <= 126) begin
            model_write(mpos, b);
            mpos = (mpos + 1) % CELLS;
        end else if (b == 13) begin
            mpos = mpos - (mpos % COLS);
        end else if (b == 10) begin
            mpos = ((mpos / COLS + 1) % ROWS) * COLS;
        end else if (b == 8) begin
            if (mpos % COLS != 0) begin
                mpos = mpos - 1;
                model_write(mpos, 32);
            end
        end else if (b == 12) begin
            for (int a = 0; a < CELLS; a++) model_write(a, 32);
            mpos = 0;
        end
    endtask

    task automatic check_writes(input string tag);
        chk($sformatf("%s_nwr", tag), got_addr.size() - gi, exp_addr.size() - ei);
        while (gi < got_addr.size() && ei < exp_addr.size()) begin
            chk($sformatf("%s_addr%0d", tag, ei), got_addr[gi], exp_addr[ei]);
            chk($sformatf("%s_data%0d", tag, ei), got_dat[gi], exp_dat[ei]);
            gi++;
            ei++;
        end
        gi = got_addr.size();
        ei = exp_addr.size();
        chk($sformatf("%s_col", tag), int'(bus.cursor_col), mpos % COLS);
        chk($sformatf("%s_row", tag), int'(bus.cursor_row), mpos / COLS);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = stop_bit;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_chk(input logic [7:0] b, input string tag);
        send_byte(b, 1'b1);
        model_byte(int'(b));
        check_writes(tag);
    endtask

    task automatic wait_sweep_end(input string tag);
        int k;
        k = 0;
        while (bus.clear_busy === 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("%s_sweep_ends", tag), int'(k < 3000), 1);
        repeat (5) @(negedge clk);
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        int busy0;
        int fe0;
        int ov0;
        int r;
        logic [7:0] b;

        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_busy", int'(bus.clear_busy), 0);
        chk("rst_col", int'(bus.cursor_col), 0);
        chk("rst_row", int'(bus.cursor_row), 0);
        chk("rst_fe", int'(bus.frame_err), 0);
        chk("rst_ov", int'(bus.overrun), 0);
        chk("rst_addr", int'(bus.wr_addr), 0);

        busy0 = busy_cyc;
        rst_n = 1'b1;
        @(negedge clk);
        chk("busy_after_release", int'(bus.clear_busy), 1);
        wait_sweep_end("init");
        chk("init_busy_cycles", busy_cyc - busy0, CELLS);
        model_byte(12);
        check_writes("init");

        send_chk(8'h41, "char_A");
        chk("char_A_addr", (got_addr.size() > 0) ? got_addr[$] : -1, 0);
        chk("char_A_col", int'(bus.cursor_col), 1);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      b = rand_print();
            else if (r == 6) b = 8'h0D;
            else if (r == 7) b = 8'h0A;
            else if (r == 8) b = 8'h08;
            else             b = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'($urandom_range(128, 255));
            send_chk(b, $sformatf("rnd%0d", i));
        end

        while (mpos / COLS != ROWS - 1) send_chk(8'h0A, "to_last_row");
        send_chk(8'h0D, "to_last_cr");
        while (mpos % COLS != COLS - 1) send_chk(rand_print(), "to_last_col");
        send_chk(8'h42, "wrap");
        chk("wrap_addr", (got_addr.size() > 0) ? got_addr[$] : -1, CELLS - 1);
        chk("wrap_data", (got_dat.size() > 0) ? got_dat[$] : -1, 8'h42);
        chk("wrap_pos", int'(bus.cursor_col) + int'(bus.cursor_row), 0);

        send_chk(8'h0A, "bs_lf1");
        send_chk(8'h0A, "bs_lf2");
        for (int i = 0; i < 5; i++) send_chk(rand_print(), "bs_fill");
        send_chk(8'h08, "bs");
        chk("bs_addr", (got_addr.size() > 0) ? got_addr[$] : -1, 164);
        chk("bs_data", (got_dat.size() > 0) ? got_dat[$] : -1, 32);
        chk("bs_col", int'(bus.cursor_col), 4);
        send_chk(8'h0D, "bs_cr");
        send_chk(8'h08, "bs_col0");

        ov0 = ov_cnt;
        send_byte(8'h0C, 1'b1);
        send_byte(8'h43, 1'b1);
        send_byte(8'h44, 1'b1);
        chk("ff_busy_during", int'(bus.clear_busy), 1);
        wait_sweep_end("ff");
        model_byte(12);
        model_byte(8'h43);
        check_writes("ff");
        chk("ff_overrun", ov_cnt - ov0, 1);
        chk("ff_held_addr", (got_addr.size() > 0) ? got_addr[$] : -1, 0);
        chk("ff_held_data", (got_dat.size() > 0) ? got_dat[$] : -1, 8'h43);

        fe0 = fe_cnt;
        send_byte(8'h55, 1'b0);
        check_writes("frame");
        chk("frame_err_pulse", fe_cnt - fe0, 1);

        fe0 = fe_cnt;
        ov0 = ov_cnt;
        bus.rx = 1'b0;
        repeat (CPB * 2 / 5) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_writes("glitch");
        chk("glitch_fe", fe_cnt - fe0, 0);
        chk("glitch_ov", ov_cnt - ov0, 0);
        send_chk(8'h5A, "after_glitch");

        send_byte(8'h0C, 1'b1);
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midsweep_rst_busy", int'(bus.clear_busy), 0);
        chk("midsweep_rst_wr_en", int'(bus.wr_en), 0);
        gi = got_addr.size();
        mpos = 0;
        busy0 = busy_cyc;
        rst_n = 1'b1;
        @(negedge clk);
        wait_sweep_end("rst2");
        chk("rst2_busy_cycles", busy_cyc - busy0, CELLS);
        model_byte(12);
        check_writes("rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_text_writer.md
Name: uart_text_writer

Overview:
Upstream feeder for the VGA glyph display. Receives ASCII bytes from the AVR serial link (avr_tx), interprets printable characters and a small set of control codes, and writes character codes into the dual-port text RAM that the VGA glyph renderer reads. It also maintains the text cursor and clears the screen after reset.

Parameters:
CLKS_PER_BIT, 100, clk cycles per UART bit (50 MHz / 500 kbaud)
COLS, 80, text columns (640 px / 8 px glyph)
ROWS, 30, text rows (480 px / 16 px glyph)
ADDR_W, 12, text RAM address width; COLS*ROWS must not exceed 2^ADDR_W

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  reset; asynchronous assert, active-low
rx  in  1  serial input from AVR Tx; idle high; asynchronous to clk
wr_en  out  1  text RAM write strobe, one cycle per write
wr_addr  out  ADDR_W  text RAM address = row*COLS + col
wr_data  out  8  character code to write
cursor_col  out  7  current cursor column, 0..COLS-1
cursor_row  out  5  current cursor row, 0..ROWS-1
clear_busy  out  1  high while the clear sweep runs
frame_err  out  1  one-cycle pulse on a bad stop bit
overrun  out  1  one-cycle pulse when a received byte is dropped

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; RX FSM goes to IDLE; holding register empty; clear FSM armed. On the first clk edge after release, the clear sweep starts and clear_busy = 1.
- rx passes through a 2-FF synchronizer before any use. This adds 2 cycles of input latency.
- RX FSM states and transitions:
  - IDLE -> START on synchronized rx = 0.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If rx = 1 (glitch), return to IDLE with no error. Otherwise go to DATA.
  - DATA: 8 bits, LSB first, each sampled CLKS_PER_BIT cycles after the previous sample.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, the byte is valid. If 0, pulse frame_err, drop the byte, and wait for rx = 1 before returning to IDLE.
- Holding register: one byte deep. A valid byte loads it. If it is still full when the next valid byte arrives, the new byte is dropped and overrun pulses. The held byte is kept.
- Command FSM: consumes the held byte only when clear_busy = 0. Processes one byte per cycle.
  - 0x20..0x7E: wr_en = 1 for one cycle, wr_addr = current position, wr_data = byte. Then advance the cursor.
    - Cursor advance: col+1; at col = COLS-1, col = 0 and row+1.
    - Row wrap: row ROWS-1 -> 0. Circular buffer, no scrolling.
  - 0x0D (CR): col = 0, no write.
  - 0x0A (LF): col = 0, row+1 with wrap, no write.
  - 0x08 (BS): if col > 0, col-1 and write 0x20 at the new position. If col = 0, no action; there is no reverse row wrap.
  - 0x0C (FF): start the clear sweep.
  - Any other byte: discarded silently.
- Write timing: wr_en asserts exactly 1 cycle after the byte is consumed. Byte consumption occurs in the cycle after the STOP sample if the command FSM is free. wr_addr and wr_data are valid only while wr_en = 1.
- Clear sweep:
  - clear_busy = 1.
  - Writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle, with wr_en held high for COLS*ROWS consecutive cycles.
  - Cursor is forced to (0,0) on the first sweep cycle.
  - clear_busy falls the cycle after the last write (address COLS*ROWS-1).
  - An FF received during a sweep is held and executed afterwards. It does not restart the sweep in progress.
  - RX continues during the sweep. At most one byte is buffered; further bytes overrun.
- wr_addr arithmetic: row*COLS + col, computed without overflow for the parameter set. Implementation choice: multiplier, or a row-base register updated on row change.
- Reset mid-sweep or mid-byte aborts immediately. After release, a full sweep restarts.

Test Plan:
- Reset release -> clear_busy = 1 for 2400 cycles; wr_en high 2400 cycles; addresses 0..2399 all with data 0x20; cursor (0,0) afterwards.
- After the clear, send "A" (0x41) at 500 kbaud -> a single write: addr 0, data 0x41; cursor_col = 1.
- Cursor at (79,29), send 0x42 -> write addr 2399, data 0x42; cursor wraps to (0,0).
- Cursor at (5,2), send 0x08 -> write addr 164, data 0x20; cursor (4,2). At col 0, 0x08 -> no write, cursor unchanged.
- Send 0x0C, then 0x43 and 0x44 back-to-back during the sweep:
  - 0x43 is held and written at addr 0 after clear_busy falls.
  - 0x44 arrives while the holding register is still full -> overrun pulse, no write.
- Byte with stop bit forced 0 -> frame_err pulse, no wr_en.
- 0.4-bit-wide low glitch on rx -> no error and no write.
